// File: rtl/prt_table.sv
// Packet table: NUM_SLOTS slots of up to MAX_BEATS beats; read beats arrive 2 cycles apart, EN_* ignored while RDY_* low.
// Optional feature PRT_TABLE_OCC_EN adds the prt_occupancy valid-slot counter.
module prt_table #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLOTS  = 16,
   parameter int MAX_BEATS  = 16,
   localparam int SW = $clog2(NUM_SLOTS),
   localparam int BW = $clog2(MAX_BEATS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  EN_start_writing_prt_entry,
   output logic                  RDY_start_writing_prt_entry,
   output logic [SW-1:0]         start_writing_prt_entry,
   input  logic                  EN_write_prt_entry,
   output logic                  RDY_write_prt_entry,
   input  logic [DATA_WIDTH-1:0] write_prt_entry_data,
   input  logic                  EN_finish_writing_prt_entry,
   output logic                  RDY_finish_writing_prt_entry,
   input  logic                  EN_invalidate_prt_entry,
   output logic                  RDY_invalidate_prt_entry,
   input  logic [SW-1:0]         invalidate_prt_entry_slot,
   input  logic                  EN_start_reading_prt_entry,
   output logic                  RDY_start_reading_prt_entry,
   input  logic [SW-1:0]         start_reading_prt_entry_slot,
   input  logic                  EN_read_prt_entry,
   output logic                  RDY_read_prt_entry,
   output logic [DATA_WIDTH:0]   read_prt_entry,
   output logic                  is_prt_slot_free,
   output logic                  RDY_is_prt_slot_free
`ifdef PRT_TABLE_OCC_EN
   ,
   output logic [SW:0]           prt_occupancy
`endif
);

   typedef enum logic {W_IDLE, W_OPEN} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_PRESENT} r_state_e;

   w_state_e              w_state_q, w_state_d;
   r_state_e              r_state_q, r_state_d;
   logic [NUM_SLOTS-1:0]  valid_q, valid_d;
   logic [BW:0]           len_q [NUM_SLOTS];
   logic [BW:0]           len_d [NUM_SLOTS];
   logic [SW-1:0]         w_slot_q, w_slot_d, r_slot_q, r_slot_d;
   logic [BW:0]           w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
   logic [BW:0]           r_len_q, r_len_d;
   logic                  r_vld_q, r_vld_d;
   logic [DATA_WIDTH:0]   rd_dat_q, rd_dat_d;
   logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS*MAX_BEATS];

   logic                  free_found;
   logic [SW-1:0]         alloc_slot;
   logic                  start_w_fire, wr_fire, fin_fire, inv_fire, inv_ok, start_r_fire, rd_fire;
   logic [SW+BW-1:0]      wr_addr, rd_addr;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  fetch_last;

   // The open write slot is not valid yet but must not be handed out twice.
   always_comb begin
      free_found = 1'b0;
      alloc_slot = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!valid_q[i] && !(w_state_q == W_OPEN && w_slot_q == SW'(i))) begin
            free_found = 1'b1;
            alloc_slot = SW'(i);
         end
      end
   end

   assign RDY_start_writing_prt_entry  = (w_state_q == W_IDLE) && free_found;
   assign start_writing_prt_entry      = alloc_slot;
   assign RDY_write_prt_entry          = (w_state_q == W_OPEN) && !w_ptr_q[BW];
   assign RDY_finish_writing_prt_entry = (w_state_q == W_OPEN) && (w_ptr_q != '0);
   assign RDY_invalidate_prt_entry     = (r_state_q == R_IDLE);
   assign RDY_start_reading_prt_entry  = (r_state_q == R_IDLE);
   assign RDY_read_prt_entry           = (r_state_q == R_PRESENT);
   assign read_prt_entry               = rd_dat_q;
   assign is_prt_slot_free             = free_found;
   assign RDY_is_prt_slot_free         = 1'b1;

   assign start_w_fire = EN_start_writing_prt_entry  && RDY_start_writing_prt_entry;
   assign wr_fire      = EN_write_prt_entry          && RDY_write_prt_entry;
   assign fin_fire     = EN_finish_writing_prt_entry && RDY_finish_writing_prt_entry;
   assign inv_fire     = EN_invalidate_prt_entry     && RDY_invalidate_prt_entry;
   assign inv_ok       = inv_fire && !(w_state_q == W_OPEN && invalidate_prt_entry_slot == w_slot_q);
   assign start_r_fire = EN_start_reading_prt_entry  && RDY_start_reading_prt_entry;
   assign rd_fire      = EN_read_prt_entry           && RDY_read_prt_entry;

   assign wr_addr    = {w_slot_q, w_ptr_q[BW-1:0]};
   assign rd_addr    = {r_slot_q, r_ptr_q[BW-1:0]};
   // Validity is snapshotted at read start, so a same-cycle finish reads as invalid.
   assign rd_word    = r_vld_q ? mem_q[rd_addr] : '0;
   assign fetch_last = !r_vld_q || ((r_ptr_q + 1'b1) == r_len_q);

   always_comb begin
      w_state_d = w_state_q;
      w_slot_d  = w_slot_q;
      w_ptr_d   = w_ptr_q;
      valid_d   = valid_q;
      len_d     = len_q;
      if (start_w_fire) begin
         w_state_d = W_OPEN;
         w_slot_d  = alloc_slot;
         w_ptr_d   = '0;
      end
      if (wr_fire) begin
         w_ptr_d = w_ptr_q + 1'b1;
      end
      if (fin_fire) begin
         valid_d[w_slot_q] = 1'b1;
         len_d[w_slot_q]   = w_ptr_d;
         w_state_d         = W_IDLE;
      end
      if (inv_ok) begin
         valid_d[invalidate_prt_entry_slot] = 1'b0;
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      r_slot_d  = r_slot_q;
      r_ptr_d   = r_ptr_q;
      r_len_d   = r_len_q;
      r_vld_d   = r_vld_q;
      rd_dat_d  = rd_dat_q;
      case (r_state_q)
         R_IDLE: begin
            if (start_r_fire) begin
               r_slot_d  = start_reading_prt_entry_slot;
               r_ptr_d   = '0;
               r_vld_d   = valid_q[start_reading_prt_entry_slot];
               r_len_d   = len_q[start_reading_prt_entry_slot];
               r_state_d = R_FETCH;
            end
         end
         R_FETCH: begin
            rd_dat_d  = {fetch_last, rd_word};
            r_state_d = R_PRESENT;
         end
         R_PRESENT: begin
            if (rd_fire) begin
               if (rd_dat_q[DATA_WIDTH]) begin
                  r_state_d = R_IDLE;
               end else begin
                  r_ptr_d   = r_ptr_q + 1'b1;
                  r_state_d = R_FETCH;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         w_slot_q  <= '0;
         w_ptr_q   <= '0;
         valid_q   <= '0;
         len_q     <= '{default: '0};
         r_state_q <= R_IDLE;
         r_slot_q  <= '0;
         r_ptr_q   <= '0;
         r_len_q   <= '0;
         r_vld_q   <= 1'b0;
         rd_dat_q  <= '0;
      end else begin
         w_state_q <= w_state_d;
         w_slot_q  <= w_slot_d;
         w_ptr_q   <= w_ptr_d;
         valid_q   <= valid_d;
         len_q     <= len_d;
         r_state_q <= r_state_d;
         r_slot_q  <= r_slot_d;
         r_ptr_q   <= r_ptr_d;
         r_len_q   <= r_len_d;
         r_vld_q   <= r_vld_d;
         rd_dat_q  <= rd_dat_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_addr] <= write_prt_entry_data;
      end
   end

`ifdef PRT_TABLE_OCC_EN
   logic [SW:0] occ_q, occ_d;
   logic        occ_dec;

   assign occ_dec = inv_ok && valid_q[invalidate_prt_entry_slot];

   always_comb begin
      occ_d = occ_q;
      if (fin_fire && !occ_dec) begin
         occ_d = occ_q + 1'b1;
      end else if (!fin_fire && occ_dec) begin
         occ_d = occ_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign prt_occupancy = occ_q;
`endif

endmodule
